// File: rtl/macc_issue_pkg.sv
// Shared definitions for the MACC issue controller: MACC op-codes, MACC pipeline
// latency and the issue FSM state encoding.
package macc_issue_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_SQ     = 3'b001;
  localparam logic [2:0] OP_MACC   = 3'b010;
  localparam logic [2:0] OP_SQ_ACC = 3'b011;
  localparam logic [2:0] OP_MADD   = 3'b100;
  localparam logic [2:0] OP_SQ_ADD = 3'b101;

  localparam int MACC_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESP
  } state_t;

endpackage

// File: rtl/macc_tag_pipe.sv
// Tag shift register tracking an issued element through the MACC pipeline;
// DEPTH cycles from i_tag to o_tag, no backpressure (the MACC never stalls).
module macc_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tag,
  output logic o_tag
);

  logic [DEPTH-1:0] r_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[DEPTH-2:0], i_tag};
    end
  end

  assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/macc_issue.sv
// Issues one dot-product / sum-of-squares reduction to a fixed-latency MACC and
// returns the result; one reduction outstanding, result held until i_res_ready.
module macc_issue
  import macc_issue_pkg::*;
#(
  parameter int OP_WIDTH  = 16,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 16,
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [LEN_WIDTH-1:0] i_cmd_len,
  input  logic                 i_cmd_square,
  input  logic                 i_op_valid,
  output logic                 o_op_ready,
  input  logic [OP_WIDTH-1:0]  i_op_a,
  input  logic [OP_WIDTH-1:0]  i_op_b,
  output logic                 o_macc_enable,
  output logic                 o_macc_clear,
  output logic [2:0]           o_macc_op_code,
  output logic [OP_WIDTH-1:0]  o_macc_op_0,
  output logic [OP_WIDTH-1:0]  o_macc_op_1,
  output logic [ACC_WIDTH-1:0] o_macc_op_add,
  input  logic [OUT_WIDTH-1:0] i_macc_out,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [OUT_WIDTH-1:0] o_res_data,
  output logic                 o_busy
);

  state_t               r_state;
  state_t               w_next_state;
  logic [LEN_WIDTH-1:0] r_count;
  logic                 r_first;
  logic                 r_square;
  logic [OUT_WIDTH-1:0] r_res_data;
  logic                 w_op_ready;
  logic                 w_issue;
  logic                 w_last;
  logic                 w_tag_out;

  assign w_op_ready = (r_state == ST_ISSUE);
  assign w_issue    = w_op_ready & i_op_valid;
  assign w_last     = (r_count == LEN_WIDTH'(1));

  assign o_op_ready    = w_op_ready;
  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_macc_enable = w_issue;
  assign o_macc_op_0   = w_issue ? i_op_a : '0;
  assign o_macc_op_1   = w_issue ? i_op_b : '0;
  assign o_macc_op_add = '0;
  assign o_res_data    = r_res_data;

  // First element overwrites the accumulator, the rest accumulate into it.
  assign o_macc_op_code = r_first ? (r_square ? OP_SQ : OP_MUL)
                                  : (r_square ? OP_SQ_ACC : OP_MACC);

  always_comb begin
    w_next_state = r_state;
    o_macc_clear = 1'b0;
    o_res_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid && !reset) begin
          if (i_cmd_len != '0) begin
            o_macc_clear = 1'b1;
            w_next_state = ST_ISSUE;
          end else begin
            w_next_state = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (w_issue && w_last) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_tag_out) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_first    <= 1'b0;
      r_square   <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && i_cmd_valid) begin
        r_count  <= i_cmd_len;
        r_square <= i_cmd_square;
        r_first  <= 1'b1;
        if (i_cmd_len == '0) r_res_data <= '0;
      end
      if (w_issue) begin
        r_count <= r_count - LEN_WIDTH'(1);
        r_first <= 1'b0;
      end
      if (r_state == ST_DRAIN && w_tag_out) r_res_data <= i_macc_out;
    end
  end

  // The last element's tag emerges in the same cycle its result is on i_macc_out.
  macc_tag_pipe #(
    .DEPTH(MACC_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .i_tag(w_issue & w_last),
    .o_tag(w_tag_out)
  );

endmodule

// File: tb/tb_macc_issue.sv
// Bench for macc_issue with a behavioural Q8.8 MACC (latency 3) and a result scoreboard.
module tb_macc_issue;
  import macc_issue_pkg::*;

  localparam int OPW = 16, ACCW = 48, OUTW = 16, LENW = 12, FRAC_BITS = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid, cmd_ready, cmd_square;
  logic [LENW-1:0] cmd_len;
  logic            op_valid, op_ready;
  logic [OPW-1:0]  op_a, op_b;
  logic            macc_enable, macc_clear;
  logic [2:0]      macc_op_code;
  logic [OPW-1:0]  macc_op_0, macc_op_1;
  logic [ACCW-1:0] macc_op_add;
  logic [OUTW-1:0] macc_out;
  logic            res_valid, res_ready;
  logic [OUTW-1:0] res_data;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int en_count = 0;
  int overlap = 0;
  logic [OUTW-1:0] exp_q[$];
  logic [2:0]      op_log[$];

  macc_issue #(.OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .OUT_WIDTH(OUTW), .LEN_WIDTH(LENW)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_len(cmd_len), .i_cmd_square(cmd_square),
    .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_a(op_a), .i_op_b(op_b),
    .o_macc_enable(macc_enable), .o_macc_clear(macc_clear), .o_macc_op_code(macc_op_code),
    .o_macc_op_0(macc_op_0), .o_macc_op_1(macc_op_1), .o_macc_op_add(macc_op_add),
    .i_macc_out(macc_out),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset) begin
      if (macc_enable) begin
        op_log.push_back(macc_op_code);
        en_count <= en_count + 1;
      end
      if (macc_enable && macc_clear) overlap <= overlap + 1;
    end
  end

  // Behavioural MACC: accumulator updates on issue, two more stages give latency 3.
  logic signed [2*OPW-1:0] p_ab, p_aa;
  logic signed [ACCW-1:0]  e_ab, e_aa, m_acc, m_d1, m_d2;
  assign p_ab = $signed(macc_op_0) * $signed(macc_op_1);
  assign p_aa = $signed(macc_op_0) * $signed(macc_op_0);
  assign e_ab = p_ab;
  assign e_aa = p_aa;
  assign macc_out = m_d2[FRAC_BITS +: OUTW];

  always @(posedge clk) begin
    if (reset) begin
      m_acc <= '0; m_d1 <= '0; m_d2 <= '0;
    end else begin
      if (macc_clear) m_acc <= '0;
      else if (macc_enable) begin
        case (macc_op_code)
          OP_MUL:    m_acc <= e_ab;
          OP_SQ:     m_acc <= e_aa;
          OP_MACC:   m_acc <= m_acc + e_ab;
          OP_SQ_ACC: m_acc <= m_acc + e_aa;
          OP_MADD:   m_acc <= e_ab + $signed(macc_op_add);
          OP_SQ_ADD: m_acc <= e_aa + $signed(macc_op_add);
          default:   m_acc <= m_acc;
        endcase
      end
      m_d1 <= m_acc;
      m_d2 <= m_d1;
    end
  end

  task automatic send_cmd(input int len, input bit sq, output bit clr);
    cmd_valid = 1'b1; cmd_len = LENW'(len); cmd_square = sq;
    @(negedge clk);
    clr = macc_clear;
    @(posedge clk); #1;
    hs_cyc = cyc;
    cmd_valid = 1'b0; cmd_len = '0; cmd_square = 1'b0;
  endtask

  task automatic send_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int gap);
    bit rdy;
    rdy = 1'b0;
    op_valid = 1'b1; op_a = a; op_b = b;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      rdy = op_ready;
      @(posedge clk); #1;
    end
    hs_cyc = cyc;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL op_handshake: op_ready=%0b after 20 cycles, required 1", rdy);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checks++;
      if (macc_enable !== 1'b0) begin
        errors++;
        $display("FAIL bubble_enable: macc_enable=%0b in gap, required 0", macc_enable);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_res(output logic [OUTW-1:0] d, output int lat, output bit ok);
    ok = 1'b0; d = '0; lat = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        d = res_data;
        lat = cyc - hs_cyc + 1;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_square = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b, required 0", res_valid); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL reset_res_data: got %h, required 0000", res_data); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready: got %0b, required 0", op_ready); end
    checks++; if (macc_enable !== 1'b0 || macc_clear !== 1'b0) begin
      errors++; $display("FAIL reset_macc_ctl: enable=%0b clear=%0b, required 0 0", macc_enable, macc_clear);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [OUTW-1:0] d, e;
    int lat;
    bit ok, clr;
    logic [2:0] exp_ops [4];
    exp_ops[0] = OP_MUL; exp_ops[1] = OP_MACC; exp_ops[2] = OP_MACC; exp_ops[3] = OP_MACC;
    op_log.delete();
    exp_q.push_back(16'h0400);
    send_cmd(4, 1'b0, clr);
    checks++; if (clr !== 1'b1) begin errors++; $display("FAIL b2b_clear: macc_clear=%0b at accept, required 1", clr); end
    for (int i = 0; i < 4; i++) send_op(16'h0100, 16'h0100, 0);
    wait_res(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL b2b_result: got %h (valid=%0b), required %h", d, ok, e); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d cycles, required 4", lat); end
    checks++; if (op_log.size() !== 4) begin errors++; $display("FAIL b2b_op_count: got %0d, required 4", op_log.size()); end
    for (int i = 0; i < 4 && i < op_log.size(); i++) begin
      checks++;
      if (op_log[i] !== exp_ops[i]) begin errors++; $display("FAIL b2b_opcode[%0d]: got %b, required %b", i, op_log[i], exp_ops[i]); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_release: res_valid=%0b cmd_ready=%0b, required 0 1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_square();
    logic [OUTW-1:0] d, e;
    int lat;
    bit ok, clr;
    op_log.delete();
    exp_q.push_back(16'h0E00);
    send_cmd(3, 1'b1, clr);
    send_op(16'h0200, 16'h7FFF, 0);
    send_op(16'h0100, 16'h7FFF, 0);
    send_op(16'h0300, 16'h7FFF, 0);
    wait_res(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL square_result: got %h (valid=%0b), required %h", d, ok, e); end
    checks++; if (op_log.size() !== 3 || op_log[0] !== OP_SQ || op_log[2] !== OP_SQ_ACC) begin
      errors++; $display("FAIL square_opcodes: count=%0d first=%b, required 3 001..011", op_log.size(), op_log[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bubbles();
    logic [OUTW-1:0] d, e;
    int lat, en0;
    bit ok, clr;
    en0 = en_count;
    exp_q.push_back(16'h0C00);
    send_cmd(3, 1'b0, clr);
    for (int i = 0; i < 3; i++) send_op(16'h0200, 16'h0200, 2);
    wait_res(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL bubble_result: got %h (valid=%0b), required %h", d, ok, e); end
    checks++; if (en_count - en0 !== 3) begin errors++; $display("FAIL bubble_enables: got %0d, required 3", en_count - en0); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [OUTW-1:0] d, e;
    int lat;
    bit ok, clr;
    res_ready = 1'b0;
    exp_q.push_back(16'h0200);
    send_cmd(2, 1'b0, clr);
    send_op(16'h0100, 16'h0100, 0);
    send_op(16'h0100, 16'h0100, 0);
    wait_res(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL bp_result: got %h (valid=%0b), required %h", d, ok, e); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== e || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: res_valid=%0b res_data=%h cmd_ready=%0b, required 1 %h 0", i, res_valid, res_data, cmd_ready, e);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: res_valid=%0b cmd_ready=%0b, required 0 1", res_valid, cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    logic [OUTW-1:0] d, e;
    int lat, en0;
    bit ok, clr;
    en0 = en_count;
    exp_q.push_back(16'h0000);
    send_cmd(0, 1'b0, clr);
    checks++; if (clr !== 1'b0) begin errors++; $display("FAIL zero_clear: macc_clear=%0b, required 0", clr); end
    wait_res(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL zero_result: got %h (valid=%0b), required %h", d, ok, e); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d cycles, required 1", lat); end
    @(posedge clk); #1;
    checks++; if (en_count !== en0) begin errors++; $display("FAIL zero_enable: %0d issues, required 0", en_count - en0); end
  endtask

  task automatic test_reset_mid();
    logic [OUTW-1:0] d, e;
    int lat;
    bit ok, clr, seen;
    send_cmd(4, 1'b0, clr);
    send_op(16'h0100, 16'h0100, 0);
    send_op(16'h0100, 16'h0100, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_result: res_valid=1 after reset, required 0"); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: cmd_ready=%0b busy=%0b, required 1 0", cmd_ready, busy);
    end
    @(posedge clk); #1;
    exp_q.push_back(16'h0100);
    send_cmd(1, 1'b0, clr);
    send_op(16'h0100, 16'h0100, 0);
    wait_res(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL midreset_result: got %h (valid=%0b), required %h", d, ok, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_square();
    test_bubbles();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL clear_enable_overlap: %0d cycles, required 0", overlap); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/macc_issue.md
MACC_ISSUE -- requirements
Module: macc_issue

Interface
REQ-001 SHALL: param OP_WIDTH, 16, operand width to MACC.
REQ-002 SHALL: param ACC_WIDTH, 48, MACC op_add width.
REQ-003 SHALL: param OUT_WIDTH, 16, MACC result width.
REQ-004 SHALL: param LEN_WIDTH, 12, command vector-length width.
REQ-005 SHALL: clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL: reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL: cmd_valid/cmd_ready  in/out  1  command handshake.
REQ-008 SHALL: cmd_len  in  LEN_WIDTH  element count; cmd_square  in  1  square mode (op_b ignored).
REQ-009 SHALL: op_valid/op_ready  in/out  1  operand-pair handshake.
REQ-010 SHALL: op_a, op_b  in  OP_WIDTH each  signed operands.
REQ-011 SHALL: macc_enable, macc_clear  out  1; macc_op_code  out  3; macc_op_0, macc_op_1  out  OP_WIDTH; macc_op_add  out  ACC_WIDTH (constant 0).
REQ-012 SHALL: macc_out  in  OUT_WIDTH  MACC result.
REQ-013 SHALL: res_valid/res_ready  out/in  1; res_data  out  OUT_WIDTH  reduction result; busy  out  1.

Function
REQ-014 SHALL: FSM states IDLE, ISSUE, DRAIN, RESP; cmd_ready=1 only in IDLE; busy=1 when not IDLE.
REQ-015 SHALL: IDLE & cmd_valid, cmd_len>0 -> latch len/square, pulse macc_clear one cycle, next state ISSUE.
REQ-016 SHALL: IDLE & cmd_valid, cmd_len==0 -> no MACC issue, res_data=0, next state RESP.
REQ-017 SHALL: op_ready=1 only in ISSUE; element issued in cycle where op_valid & op_ready.
REQ-018 SHALL: macc_enable = issue (combinational); macc_op_0=op_a, macc_op_1=op_b on issue, both 0 otherwise.
REQ-019 SHALL: macc_op_code = {1'b0,1'b0,square} for first element, {1'b0,1'b1,square} for later elements (MUL/SQ then MACC/SQ-ACC).
REQ-020 SHALL: op_valid low in ISSUE -> macc_enable 0, counters hold (bubble); result unaffected.
REQ-021 SHALL: down-counter of remaining elements; issue with count==1 marks last, next state DRAIN.
REQ-022 SHALL: MACC latency fixed at 3 (localparam MACC_LATENCY): element issued in cycle c visible on macc_out in cycle c+3.
REQ-023 SHALL: 3-deep tag shift register carries issue&last; on tag exit, res_data <= macc_out, state RESP; res_valid=1 in cycle c+4 of last issue.
REQ-024 SHALL: RESP holds res_valid and res_data stable until res_ready; on handshake -> IDLE, res_valid 0 next cycle.
REQ-025 SHALL: no new command accepted while busy (single outstanding reduction).
REQ-026 SHALL: macc_clear never coincide with macc_enable.

Reset
REQ-027 SHALL: reset -> state IDLE, counters 0, tags 0, res_valid 0, res_data 0, macc_enable 0, macc_clear 0, op_ready 0, cmd_ready 1 next cycle.
REQ-028 SHALL: reset mid-ISSUE/DRAIN/RESP abandons reduction with no res_valid pulse.

Structure
REQ-029 SHALL: shared package holds MACC op-code constants (MUL 000, SQ 001, MACC 010, SQ_ACC 011, MADD 100, SQ_ADD 101), MACC_LATENCY, FSM state enum.
REQ-030 SHALL: tag shift register as sub-module macc_tag_pipe (param DEPTH=MACC_LATENCY); all else in macc_issue.

Verification (bench instantiates macc, FRAC_BITS=8)
REQ-031 SHALL: len 4, square 0, a=b=0x0100 x4 back-to-back -> op codes 000,010,010,010; res_data 0x0400; res_valid 4 cycles after last op handshake.
REQ-032 SHALL: len 3, square 1, a=0x0200,0x0100,0x0300, b=0x7FFF -> res_data 0x0E00.
REQ-033 SHALL: len 3, a=b=0x0200 with 2-cycle op_valid gaps -> macc_enable low in gaps; res_data 0x0C00.
REQ-034 SHALL: res_ready low 10 cycles -> res_valid/res_data stable, cmd_ready 0; res_ready high -> IDLE next cycle.
REQ-035 SHALL: cmd_len 0 -> no macc_enable, res_valid next cycle, res_data 0x0000.
REQ-036 SHALL: reset after 2 of 4 elements, then len 1, a=b=0x0100 -> no stale result; res_data 0x0100.
